// File: rtl/mat_inv3x3_fx_if.sv
// rtl/mat_inv3x3_fx_if.sv - request/result bus of the fixed-point 3x3 matrix inverse
//
// Purpose : groups the start/busy/done handshake, the matrix operand and the
//           results of mat_inv3x3_fx into one bundle.
// Signals : start     requester -> block, one-cycle request
//           mat_in    requester -> block, 9 signed DATA_W elements, row-major
//           busy      block -> requester, operation in flight
//           done      block -> requester, one-cycle completion pulse
//           singular  block -> requester, determinant was zero
//           ovf       block -> requester, at least one element saturated
//           det_out   block -> requester, signed determinant (3*DATA_W+2 bits)
//           inv_out   block -> requester, 9 signed OUT_W fixed-point elements
// Modports: master = requester, slave = mat_inv3x3_fx.
interface mat_inv3x3_fx_if #(
  parameter int DATA_W = 13,
  parameter int OUT_W  = 32
);
  logic                  start;
  logic [9*DATA_W-1:0]   mat_in;
  logic                  busy;
  logic                  done;
  logic                  singular;
  logic                  ovf;
  logic [3*DATA_W+1:0]   det_out;
  logic [9*OUT_W-1:0]    inv_out;

  modport master (
    output start, mat_in,
    input  busy, done, singular, ovf, det_out, inv_out
  );

  modport slave (
    input  start, mat_in,
    output busy, done, singular, ovf, det_out, inv_out
  );
endinterface

// File: rtl/mat_inv3x3_fx.sv
// rtl/mat_inv3x3_fx.sv - fixed-point 3x3 matrix inverse with a shared bit-serial divider
//
// Purpose : latches a signed 3x3 matrix on start, registers its nine cofactors,
//           then its determinant, and divides each adjugate element (scaled by
//           2^FRAC_W) by the determinant using one restoring divider, producing
//           saturated signed Q(OUT_W-FRAC_W).FRAC_W results.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset, aborts any operation
//           bus    mat_inv3x3_fx_if slave modport (start, mat_in, busy, done,
//                  singular, ovf, det_out, inv_out)
module mat_inv3x3_fx #(
  parameter int DATA_W = 13,
  parameter int FRAC_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  mat_inv3x3_fx_if.slave bus
);

  localparam int CW    = 2*DATA_W + 1;               // cofactor width
  localparam int DW    = 3*DATA_W + 2;               // determinant width
  localparam int QW    = CW + FRAC_W;                // dividend / quotient width
  localparam int EW    = ((QW > OUT_W) ? QW : OUT_W) + 1;
  localparam int CNT_W = $clog2(QW + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COF,
    S_DET,
    S_CHECK,
    S_DIV
  } state_t;

  state_t                   state;
  logic signed [DATA_W-1:0] a_r   [9];
  logic signed [CW-1:0]     cof_r [9];
  logic signed [DW-1:0]     det_r;
  logic [DW-1:0]            dmag_r;
  logic                     det_neg_r;
  logic [QW-1:0]            dvd_r;
  logic [QW-1:0]            quo_r;
  logic [DW-1:0]            rem_r;
  logic                     neg_r;
  logic [CNT_W-1:0]         cnt_r;
  logic [3:0]               k_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     singular_r;
  logic                     ovf_r;
  logic [9*OUT_W-1:0]       inv_r;

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.singular = singular_r;
  assign bus.ovf      = ovf_r;
  assign bus.det_out  = det_r;
  assign bus.inv_out  = inv_r;

  // Cyclic index form: for a 3x3 matrix the product of the "next" rows/cols
  // already carries the (-1)^(i+j) sign of the cofactor.
  function automatic logic signed [CW-1:0] cof2(
    input logic signed [DATA_W-1:0] p,
    input logic signed [DATA_W-1:0] q,
    input logic signed [DATA_W-1:0] r,
    input logic signed [DATA_W-1:0] s
  );
    logic signed [CW-1:0] pe, qe, re, se;
    pe = CW'(p);
    qe = CW'(q);
    re = CW'(r);
    se = CW'(s);
    return pe*qe - re*se;
  endfunction

  // Determinant by expansion along row 0, exact in DW bits.
  logic signed [DW-1:0] det_c;
  always_comb begin
    det_c = '0;
    for (int j = 0; j < 3; j++) begin
      det_c = det_c + DW'(a_r[j]) * DW'(cof_r[j]);
    end
  end

  // Output element k = 3i+j takes the transposed cofactor C(j,i).
  logic [3:0] adj_idx;
  always_comb begin
    case (k_r)
      4'd0:    adj_idx = 4'd0;
      4'd1:    adj_idx = 4'd3;
      4'd2:    adj_idx = 4'd6;
      4'd3:    adj_idx = 4'd1;
      4'd4:    adj_idx = 4'd4;
      4'd5:    adj_idx = 4'd7;
      4'd6:    adj_idx = 4'd2;
      4'd7:    adj_idx = 4'd5;
      4'd8:    adj_idx = 4'd8;
      default: adj_idx = 4'd0;
    endcase
  end

  logic signed [CW-1:0] cof_sel;
  logic [CW-1:0]        cof_mag;
  always_comb begin
    cof_sel = cof_r[adj_idx];
    cof_mag = cof_sel[CW-1] ? $unsigned(-cof_sel) : $unsigned(cof_sel);
  end

  // One restoring step plus saturation of the quotient that step completes.
  logic [DW:0]      trial;
  logic             q_bit;
  logic [DW-1:0]    rem_nxt;
  logic [QW-1:0]    quo_nxt;
  logic [EW-1:0]    q_ext;
  logic [EW-1:0]    lim_pos;
  logic [EW-1:0]    lim_neg;
  logic [EW-1:0]    neg_ext;
  logic [OUT_W-1:0] sat_val;
  logic             sat_hit;
  always_comb begin
    trial   = {rem_r, dvd_r[QW-1]};
    q_bit   = (trial >= {1'b0, dmag_r});
    rem_nxt = q_bit ? DW'(trial - {1'b0, dmag_r}) : trial[DW-1:0];
    quo_nxt = {quo_r[QW-2:0], q_bit};
    q_ext   = EW'(quo_nxt);
    lim_pos = EW'({1'b0, {(OUT_W-1){1'b1}}});
    lim_neg = lim_pos + EW'(1);
    neg_ext = EW'(0) - q_ext;
    sat_hit = 1'b0;
    if (neg_r) begin
      if (q_ext > lim_neg) begin
        sat_hit = 1'b1;
        sat_val = {1'b1, {(OUT_W-1){1'b0}}};
      end else begin
        sat_val = neg_ext[OUT_W-1:0];
      end
    end else begin
      if (q_ext > lim_pos) begin
        sat_hit = 1'b1;
        sat_val = {1'b0, {(OUT_W-1){1'b1}}};
      end else begin
        sat_val = q_ext[OUT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      for (int i = 0; i < 9; i++) begin
        a_r[i]   <= '0;
        cof_r[i] <= '0;
      end
      det_r      <= '0;
      dmag_r     <= '0;
      det_neg_r  <= 1'b0;
      dvd_r      <= '0;
      quo_r      <= '0;
      rem_r      <= '0;
      neg_r      <= 1'b0;
      cnt_r      <= '0;
      k_r        <= '0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      singular_r <= 1'b0;
      ovf_r      <= 1'b0;
      inv_r      <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            for (int i = 0; i < 9; i++) begin
              a_r[i] <= bus.mat_in[i*DATA_W +: DATA_W];
            end
            busy_r     <= 1'b1;
            singular_r <= 1'b0;
            ovf_r      <= 1'b0;
            state      <= S_COF;
          end
        end

        S_COF: begin
          for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
              cof_r[3*i+j] <= cof2(a_r[3*((i+1)%3) + (j+1)%3],
                                   a_r[3*((i+2)%3) + (j+2)%3],
                                   a_r[3*((i+1)%3) + (j+2)%3],
                                   a_r[3*((i+2)%3) + (j+1)%3]);
            end
          end
          state <= S_DET;
        end

        S_DET: begin
          det_r <= det_c;
          state <= S_CHECK;
        end

        S_CHECK: begin
          if (det_r == '0) begin
            singular_r <= 1'b1;
            inv_r      <= '0;
            done_r     <= 1'b1;
            busy_r     <= 1'b0;
            state      <= S_IDLE;
          end else begin
            dmag_r    <= det_r[DW-1] ? $unsigned(-det_r) : $unsigned(det_r);
            det_neg_r <= det_r[DW-1];
            k_r       <= '0;
            cnt_r     <= '0;
            state     <= S_DIV;
          end
        end

        S_DIV: begin
          if (cnt_r == '0) begin
            // Setup cycle: load |C| * 2^FRAC_W for the current element.
            dvd_r <= {cof_mag, {FRAC_W{1'b0}}};
            rem_r <= '0;
            quo_r <= '0;
            neg_r <= cof_sel[CW-1] ^ det_neg_r;
            cnt_r <= CNT_W'(1);
          end else begin
            dvd_r <= {dvd_r[QW-2:0], 1'b0};
            rem_r <= rem_nxt;
            quo_r <= quo_nxt;
            if (cnt_r == CNT_W'(QW)) begin
              inv_r[k_r*OUT_W +: OUT_W] <= sat_val;
              if (sat_hit) begin
                ovf_r <= 1'b1;
              end
              cnt_r <= '0;
              if (k_r == 4'd8) begin
                done_r <= 1'b1;
                busy_r <= 1'b0;
                state  <= S_IDLE;
              end else begin
                k_r <= k_r + 4'd1;
              end
            end else begin
              cnt_r <= cnt_r + CNT_W'(1);
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
